// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a one-entry skid register, synchronous flush and saturating stall counter.
// Latency 1 cycle; in_ready, out_valid and out_data are decoded from flops, so there is no ready-to-ready combinational path.
module pipe_stage_skid #(
    parameter int                DATA_W  = 72,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter int                CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    // The encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              in_fire;
    logic              out_fire;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign occupancy = state;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_nxt    = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush kills everything held, including a bundle accepted this cycle; data flops keep their contents.
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data <= RST_VAL;
            skid_data <= RST_VAL;
        end else begin
            if (load_main_in) begin
                main_data <= in_data;
            end else if (load_main_skid) begin
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register that replaces fixed stall-gated stage buffers with a valid/ready handshake, a one-entry skid register, synchronous flush and a stall-cycle counter. It sits between two CPU pipeline stages, e.g. MEM→WB or EX→MEM, carrying a packed control-plus-data bundle of DATA_W bits. Neither direction has a combinational path from ready to ready, so stages can be chained without long backpressure timing paths.

## Interface
- DATA_W, default 72: width of the packed stage bundle (data, rd, control bits).
- RST_VAL, default '0: reset value of the main and skid data registers.
- CNT_W, default 16: width of the stall-cycle counter.

Ports:
- clk  in  1  stage clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high; one clock domain.
- flush  in  1  synchronous kill of all held entries (branch mispredict or trap).
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept; registered, not a function of out_ready.
- in_data  in  DATA_W  upstream bundle.
- out_valid  out  1  out_data holds a live bundle.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  bundle from the main register.
- occupancy  out  2  entries held: 0, 1 or 2.
- stall_cycles  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Storage: a main register (drives out_data) and a skid register, each with its own valid bit.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- States, encoded by occupancy:
  - EMPTY (0): in_ready=1, out_valid=0.
  - ONE (1): in_ready=1, out_valid=1.
  - FULL (2): in_ready=0, out_valid=1.
- EMPTY: on in_fire, main<=in_data and go to ONE. Otherwise hold.
- ONE:
  - in_fire & out_fire: main<=in_data, stay in ONE.
  - in_fire only: skid<=in_data, go to FULL.
  - out_fire only: go to EMPTY.
  - Neither: hold.
- FULL: in_fire cannot occur. On out_fire, main<=skid and go to ONE. Otherwise hold.
- Ordering is strict FIFO. No bundle is ever duplicated or dropped except by flush.
- flush has highest priority:
  - Next state is EMPTY regardless of in_fire or out_fire.
  - A bundle accepted on the flush cycle is discarded.
  - Data registers keep their contents; only valid bits clear.
  - Outputs during the flush cycle itself are unaffected, so a downstream out_fire in that cycle counts as a consumed bundle.
- stall_cycles:
  - Increments by 1 in each cycle with out_valid & !out_ready, including the flush cycle.
  - Saturates at 2^CNT_W−1.
  - Cleared only by rst; flush does not clear it.
- occupancy always equals main_valid + skid_valid.

## Timing
- Reset values:
  - out_valid=0, in_ready=1, occupancy=0, stall_cycles=0.
  - out_data=RST_VAL, skid=RST_VAL.
- rst asserted mid-transfer clears state immediately (asynchronously). The first handshake is possible on the first rising edge after rst deasserts.
- Latency: in_fire at edge N gives out_valid=1 with that data after edge N, from EMPTY or from ONE-with-out_fire.
- Throughput: 1 bundle/cycle sustained while out_ready=1.
- Backpressure:
  - in_ready drops on the edge after the second unconsumed accept.
  - It returns to 1 on the edge after the out_fire that leaves FULL.
- in_ready, out_valid and out_data come from flops only.
- After a flush at edge N: out_valid=0 and in_ready=1 after edge N.

## Test plan
- Streaming: out_ready=1; send 0x01..0x08 on consecutive cycles, in_valid=1 → out_data 0x01..0x08 on consecutive cycles, each one cycle after its accept; occupancy stays 1; stall_cycles=0.
- Backpressure into skid: out_ready=0; offer 0xA1, 0xA2, 0xA3 → 0xA1 and 0xA2 accepted; occupancy=2; in_ready=0; 0xA3 held upstream. Raise out_ready → output order 0xA1, 0xA2, 0xA3; stall_cycles equals the count of cycles with out_ready=0 while out_valid=1.
- Simultaneous in_fire/out_fire in ONE: main=0x10 and in_data=0x11 on the same cycle with out_ready=1 → 0x10 consumed, out_data=0x11 next cycle, occupancy stays 1.
- Flush in FULL with in_valid=1, data 0x55 → next cycle occupancy=0, out_valid=0, in_ready=1; 0x55 never appears at the output; stall_cycles is not cleared.
- Counter saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles → stall_cycles=15 and holds there.
- Asynchronous reset mid-FULL: rst pulsed between edges → out_valid=0, occupancy=0, out_data=RST_VAL immediately; a bundle sent after rst deasserts passes normally.
